sound_arbiter: RTL and testbench
================================

SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter NOTE_LEN, default 12500000, clock cycles per note.
REQ-002 Parameter GAP_LEN, default 2500000, silent clock cycles after each sound's last note.
REQ-003 Parameter HP_UNIT, default 16000, clock cycles per tone-table unit.
REQ-004 Port clk  input  1  system clock; all state changes on posedge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port req  input  4  one-cycle sound requests: [0] catch, [1] hit, [2] win, [3] lose.
REQ-007 Port clr  input  1  synchronous abort, used on game restart.
REQ-008 Port mute  input  1  forces buzzer low; sequencing continues.
REQ-009 Port buzzer  output  1  square-wave tone to the speaker pin.
REQ-010 Port busy  output  1  high while a sound occupies the buzzer.
REQ-011 Port grant  output  4  one-hot sound currently playing, 0 when idle.
REQ-012 Port pending  output  4  latched, not-yet-granted requests.
REQ-013 Port done  output  1  one-cycle pulse on normal completion of a sound.

Function
REQ-014 Each req bit high at a posedge sets the matching pending bit; repeat requests while pending collapse into one.
REQ-015 FSM states are IDLE, NOTE0, NOTE1 and GAP.
REQ-016 In IDLE with pending!=0, the next edge enters NOTE0, sets grant one-hot to the highest pending index (3>2>1>0), clears that pending bit and zeroes note and tone counters.
REQ-017 A req set and a grant clear on the same bit in the same edge leave the bit set.
REQ-018 NOTE0 and NOTE1 each last exactly NOTE_LEN cycles, GAP exactly GAP_LEN cycles, then IDLE; total busy time is 2*NOTE_LEN+GAP_LEN.
REQ-019 Tone half-periods in HP_UNIT multiples (note0,note1): catch (3,2); hit (6,8); win (4,3); lose (8,12).
REQ-020 At each note start, buzzer=0 and the tone counter=0; buzzer toggles whenever the tone counter reaches half-period-1, and the counter then wraps to 0.
REQ-021 Buzzer is 0 in IDLE and GAP, and whenever mute=1.
REQ-022 busy is 1 exactly in NOTE0, NOTE1 and GAP; grant is nonzero exactly when busy=1.
REQ-023 done is 1 for exactly the first IDLE cycle after a normally completed GAP.
REQ-024 Request-to-grant latency is 2 cycles (req sampled, then pending visible, then grant); back-to-back sounds have one IDLE cycle between them.
REQ-025 clr=1 forces IDLE, clears pending, grant, buzzer and counters on the next edge, and suppresses done; req in the same cycle as clr is discarded.
REQ-026 A req for the sound currently playing re-pends it; it replays after the current sound finishes.
REQ-027 Note and tone counters are 24 bits; NOTE_LEN and GAP_LEN must be >= 1.

Reset
REQ-028 On rst=1, immediately and independent of clk: state IDLE; buzzer, busy, grant, pending, done and all counters 0.
REQ-029 A reset mid-sound silences buzzer asynchronously; no done pulse follows, and no pending request survives.

Configuration
REQ-030 Macro SOUND_PREEMPT_EN: when defined, in NOTE0/NOTE1/GAP a pending bit of higher priority than grant restarts NOTE0 with that sound on the next edge; the aborted sound gives no done and is not re-pended.
REQ-031 Without SOUND_PREEMPT_EN, a granted sound always runs to completion, and higher-priority requests wait in pending.

Verification (NOTE_LEN=8, GAP_LEN=4, HP_UNIT=1)
REQ-032 req=0001 at cycle 0 -> pending=0001 at cycle 1; grant=0001 and busy at cycles 2-21; buzzer toggles every 3 cycles at 2-9 and every 2 cycles at 10-17; buzzer 0 at 18-21; done at cycle 22.
REQ-033 req=0011 at cycle 0 -> hit granted at cycle 2 and pending=0001; catch granted at cycle 23 after done at cycle 22.
REQ-034 Hit playing, req=1000 at a NOTE1 cycle: with SOUND_PREEMPT_EN, grant=1000 at the next edge plus 1, hit gives no done; without the macro, lose is granted one cycle after hit's done.
REQ-035 mute=1 throughout a win sound -> buzzer stays 0; busy, grant and done timing are identical to the unmuted case.
REQ-036 clr at cycle 5 of a sound with pending=0100 -> at cycle 6 state IDLE, grant, pending and busy are 0; no done pulse.
REQ-037 rst asserted mid-NOTE0 between clock edges -> buzzer, busy and grant are 0 before the next edge; after release, a new req is granted with a latency of 2.

Source files
------------

// File: rtl/sound_arbiter.sv
// sound_arbiter -- priority arbiter and two-note tone sequencer for a buzzer.
//
// Each request bit latches into a pending set. When idle, the highest pending
// sound (lose > win > hit > catch) is granted. It then plays two square-wave
// notes of NOTE_LEN cycles each, followed by GAP_LEN silent cycles.
//
// Optional feature macro: SOUND_PREEMPT_EN. When it is defined, a pending sound
// of higher priority restarts NOTE0 with that sound, and the aborted sound is
// dropped without a done pulse.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   req[3:0] in   one-cycle requests: [0] catch, [1] hit, [2] win, [3] lose
//   clr      in   synchronous abort; also discards same-cycle requests
//   mute     in   forces buzzer low; sequencing is unaffected
//   buzzer   out  square-wave tone
//   busy     out  high in NOTE0, NOTE1 and GAP
//   grant    out  one-hot sound currently playing
//   pending  out  latched requests not yet granted
//   done     out  one-cycle pulse after a sound completes normally
module sound_arbiter #(
   parameter int NOTE_LEN = 12500000,
   parameter int GAP_LEN  = 2500000,
   parameter int HP_UNIT  = 16000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       clr,
   input  logic       mute,
   output logic       buzzer,
   output logic       busy,
   output logic [3:0] grant,
   output logic [3:0] pending,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NOTE0 = 2'd1,
      NOTE1 = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t      state_q;
   logic [23:0] note_q;
   logic [23:0] tone_q;
   logic        tone_lvl_q;
   logic        busy_q;
   logic        done_q;
   logic [3:0]  grant_q;
   logic [3:0]  pending_q;

   logic [3:0]  pick_s;
   logic        start_s;
   logic [3:0]  pending_d;
   logic [3:0]  units_s;
   logic [23:0] hp_s;
   logic        tone_wrap_s;

   // Highest-priority pending sound as a one-hot vector.
   always_comb begin
      pick_s = 4'b0000;
      if (pending_q[3]) begin
         pick_s = 4'b1000;
      end else if (pending_q[2]) begin
         pick_s = 4'b0100;
      end else if (pending_q[1]) begin
         pick_s = 4'b0010;
      end else if (pending_q[0]) begin
         pick_s = 4'b0001;
      end else begin
         pick_s = 4'b0000;
      end
   end

   // Decide whether a new sound starts at the next edge.
   // grant is zero in IDLE, so with preemption the single comparison also covers
   // starting from idle. A one-hot vector with a higher bit set is numerically
   // larger, so the comparison also tests priority.
   always_comb begin
`ifdef SOUND_PREEMPT_EN
      start_s = (pending_q != 4'b0000) && (pick_s > grant_q);
`else
      start_s = (state_q == IDLE) && (pending_q != 4'b0000);
`endif
   end

   // Next pending set. A request on the bit being granted survives the clear.
   always_comb begin
      pending_d = (pending_q & ~(start_s ? pick_s : 4'b0000)) | req;
   end

   // Half-period of the current note in HP_UNIT multiples.
   always_comb begin
      units_s = 4'd1;
      case (grant_q)
         4'b0001: units_s = (state_q == NOTE1) ? 4'd2  : 4'd3;
         4'b0010: units_s = (state_q == NOTE1) ? 4'd8  : 4'd6;
         4'b0100: units_s = (state_q == NOTE1) ? 4'd3  : 4'd4;
         4'b1000: units_s = (state_q == NOTE1) ? 4'd12 : 4'd8;
         default: units_s = 4'd1;
      endcase
      hp_s        = 24'(units_s) * 24'(HP_UNIT);
      tone_wrap_s = (tone_q == (hp_s - 24'd1));
   end

   // Sequencer FSM with its registered outputs and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         note_q     <= 24'd0;
         tone_q     <= 24'd0;
         tone_lvl_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         grant_q    <= 4'b0000;
         pending_q  <= 4'b0000;
      end else if (clr) begin
         state_q    <= IDLE;
         note_q     <= 24'd0;
         tone_q     <= 24'd0;
         tone_lvl_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         grant_q    <= 4'b0000;
         pending_q  <= 4'b0000;
      end else begin
         pending_q <= pending_d;
         done_q    <= 1'b0;
         if (start_s) begin
            state_q    <= NOTE0;
            grant_q    <= pick_s;
            busy_q     <= 1'b1;
            note_q     <= 24'd0;
            tone_q     <= 24'd0;
            tone_lvl_q <= 1'b0;
         end else begin
            case (state_q)
               NOTE0, NOTE1: begin
                  if (note_q == 24'(NOTE_LEN - 1)) begin
                     // Each note starts with the tone low and the phase counter cleared.
                     state_q    <= (state_q == NOTE0) ? NOTE1 : GAP;
                     note_q     <= 24'd0;
                     tone_q     <= 24'd0;
                     tone_lvl_q <= 1'b0;
                  end else begin
                     note_q <= note_q + 24'd1;
                     if (tone_wrap_s) begin
                        tone_q     <= 24'd0;
                        tone_lvl_q <= ~tone_lvl_q;
                     end else begin
                        tone_q <= tone_q + 24'd1;
                     end
                  end
               end
               GAP: begin
                  if (note_q == 24'(GAP_LEN - 1)) begin
                     state_q <= IDLE;
                     note_q  <= 24'd0;
                     grant_q <= 4'b0000;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     note_q <= note_q + 24'd1;
                  end
               end
               IDLE: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
                  grant_q <= 4'b0000;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign buzzer  = tone_lvl_q & ~mute;
   assign busy    = busy_q;
   assign grant   = grant_q;
   assign pending = pending_q;
   assign done    = done_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Self-checking bench for sound_arbiter with NOTE_LEN=8, GAP_LEN=4, HP_UNIT=1.
module tb_sound_arbiter;
   localparam int NL = 8;
   localparam int GL = 4;
   localparam int HU = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       clr;
   logic       mute;
   logic       buzzer;
   logic       busy;
   logic [3:0] grant;
   logic [3:0] pending;
   logic       done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sound_arbiter #(.NOTE_LEN(NL), .GAP_LEN(GL), .HP_UNIT(HU)) dut (
      .clk(clk), .rst(rst), .req(req), .clr(clr), .mute(mute),
      .buzzer(buzzer), .busy(busy), .grant(grant), .pending(pending), .done(done)
   );

   task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Output snapshot: {buzzer, busy, grant, pending, done}
   function automatic logic [10:0] mk(input logic bz, input logic bs, input logic [3:0] g,
                                      input logic [3:0] p, input logic d);
      return {bz, bs, g, p, d};
   endfunction

   function automatic logic [10:0] outs();
      return {buzzer, busy, grant, pending, done};
   endfunction

   task automatic do_reset();
      req = 4'd0; clr = 1'b0; mute = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [10:0] exp;
   } vec_t;
   vec_t tbl[24];

   // ---------------- behavioural reference model ----------------
   int         hp_tab[4][2] = '{'{3, 2}, '{6, 8}, '{4, 3}, '{8, 12}};
   int         m_play, m_snd, m_t;
   logic [3:0] m_pend;
   logic       m_done;

   function automatic int top_idx(input logic [3:0] p);
      for (int i = 3; i >= 0; i--) if (p[i]) return i;
      return -1;
   endfunction

   function automatic logic [10:0] model_out(input logic mu);
      logic bz;
      logic [3:0] g;
      bz = 1'b0;
      g = 4'd0;
      if (m_play != 0) begin
         g = 4'(1 << m_snd);
         if (m_t < 2 * NL && !mu)
            bz = (((m_t % NL) / (hp_tab[m_snd][m_t / NL] * HU)) % 2) == 1;
      end
      return mk(bz, m_play != 0, g, m_pend, m_done);
   endfunction

   task automatic model_edge(input logic [3:0] r, input logic c);
      int hi;
      logic [3:0] took;
      if (c) begin
         m_play = 0; m_pend = 4'd0; m_done = 1'b0; m_t = 0;
      end else begin
         took = 4'd0;
         m_done = 1'b0;
         hi = top_idx(m_pend);
`ifdef SOUND_PREEMPT_EN
         if (hi >= 0 && (m_play == 0 || hi > m_snd)) begin
`else
         if (hi >= 0 && m_play == 0) begin
`endif
            m_play = 1; m_snd = hi; m_t = 0; took = 4'(1 << hi);
         end else if (m_play != 0) begin
            if (m_t + 1 == 2 * NL + GL) begin
               m_play = 0; m_done = 1'b1;
            end else begin
               m_t++;
            end
         end
         m_pend = (m_pend & ~took) | r;
      end
   endtask

   logic [23:0] bz_pat;
   logic [3:0]  eg;
   logic        ed;
   logic        eb;

   initial begin
      // asynchronous reset state before any clock edge
      req = 4'd0; clr = 1'b0; mute = 1'b0; rst = 1'b1;
      #2;
      chk("reset_state", 0, 32'(outs()), 32'(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0)));
      @(posedge clk); #1;
      rst = 1'b0;

      // ---- table: single catch sound ----
      bz_pat = 24'd0;
      bz_pat[5] = 1'b1; bz_pat[6] = 1'b1; bz_pat[7] = 1'b1;
      bz_pat[12] = 1'b1; bz_pat[13] = 1'b1; bz_pat[16] = 1'b1; bz_pat[17] = 1'b1;
      tbl[0] = '{4'b0001, mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0)};
      tbl[1] = '{4'b0000, mk(1'b0, 1'b0, 4'd0, 4'b0001, 1'b0)};
      for (int i = 2; i < 22; i++) tbl[i] = '{4'b0000, mk(bz_pat[i], 1'b1, 4'b0001, 4'd0, 1'b0)};
      tbl[22] = '{4'b0000, mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1)};
      tbl[23] = '{4'b0000, mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0)};
      for (int i = 0; i < 24; i++) begin
         req = tbl[i].req;
         @(negedge clk);
         chk("catch_table", i, 32'(outs()), 32'(tbl[i].exp));
         @(posedge clk); #1;
      end

      // ---- two simultaneous requests: hit first, then catch ----
      do_reset();
      for (int c = 0; c < 25; c++) begin
         req = (c == 0) ? 4'b0011 : 4'b0000;
         @(negedge clk);
         if (c == 2)  chk("dual_c2", c, 32'({grant, pending}), 32'({4'b0010, 4'b0001}));
         if (c == 22) chk("dual_done", c, 32'({grant, done}), 32'({4'b0000, 1'b1}));
         if (c == 23) chk("dual_c23", c, 32'({grant, pending, busy}), 32'({4'b0001, 4'b0000, 1'b1}));
         @(posedge clk); #1;
      end

      // ---- higher-priority request while hit plays NOTE1 ----
      do_reset();
      for (int c = 0; c < 37; c++) begin
         req = (c == 0) ? 4'b0010 : (c == 12) ? 4'b1000 : 4'b0000;
`ifdef SOUND_PREEMPT_EN
         eg = (c >= 2 && c < 14) ? 4'b0010 : (c >= 14 && c < 34) ? 4'b1000 : 4'b0000;
         ed = (c == 34);
`else
         eg = (c >= 2 && c < 22) ? 4'b0010 : (c >= 23) ? 4'b1000 : 4'b0000;
         ed = (c == 22);
`endif
         @(negedge clk);
         chk("preempt_seq", c, 32'({grant, done}), 32'({eg, ed}));
         @(posedge clk); #1;
      end

      // ---- muted win: silent, timing unchanged ----
      do_reset();
      mute = 1'b1;
      for (int c = 0; c < 24; c++) begin
         req = (c == 0) ? 4'b0100 : 4'b0000;
         eb = (c >= 2 && c <= 21);
         @(negedge clk);
         chk("mute_win", c, 32'({buzzer, busy, grant, done}),
             32'({1'b0, eb, (eb ? 4'b0100 : 4'b0000), (c == 22)}));
         @(posedge clk); #1;
      end
      mute = 1'b0;

      // ---- clr mid-sound with win pending ----
      do_reset();
      for (int c = 0; c < 26; c++) begin
         req = (c == 0) ? 4'b0001 : (c == 3) ? 4'b0100 : 4'b0000;
         clr = (c == 5);
         @(negedge clk);
         if (c == 5) chk("clr_before", c, 32'({grant, pending}), 32'({4'b0001, 4'b0100}));
         if (c >= 6) chk("clr_after", c, 32'(outs()), 32'(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0)));
         @(posedge clk); #1;
      end
      clr = 1'b0;

      // ---- asynchronous reset mid-NOTE0 with buzzer high and win pending ----
      do_reset();
      for (int c = 0; c < 6; c++) begin
         req = (c == 0) ? 4'b0001 : (c == 3) ? 4'b0100 : 4'b0000;
         @(negedge clk);
         if (c == 5) chk("pre_rst", c, 32'({buzzer, busy, pending}), 32'({1'b1, 1'b1, 4'b0100}));
         if (c < 5) begin
            @(posedge clk); #1;
         end
      end
      #2 rst = 1'b1;
      #1 chk("async_rst", 5, 32'(outs()), 32'(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0)));
      @(posedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
         req = (c == 0) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         if (c == 1) chk("post_rst_c1", c, 32'({grant, pending, done}), 32'({4'b0000, 4'b0010, 1'b0}));
         if (c == 2) chk("post_rst_c2", c, 32'({grant, busy}), 32'({4'b0010, 1'b1}));
         @(posedge clk); #1;
      end

      // ---- randomized run against the reference model ----
      do_reset();
      m_play = 0; m_snd = 0; m_t = 0; m_pend = 4'd0; m_done = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         req  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         if ($urandom_range(0, 19) == 0) mute = ~mute;
         clr  = ($urandom_range(0, 249) == 0);
         @(negedge clk);
         chk("random", n, 32'(outs()), 32'(model_out(mute)));
         @(posedge clk);
         model_edge(req, clr);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
